// File: rtl/jtkiwi_shr_pkg.sv
// rtl/jtkiwi_shr_pkg.sv - shared types and defaults for the sub-CPU shared RAM port
package jtkiwi_shr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_HOLD = 2'd2
  } shr_state_t;

  localparam logic [2:0] WIN_DEF = 3'b110;

endpackage

// File: rtl/jtkiwi_rstsync.sv
// rtl/jtkiwi_rstsync.sv - two-flop synchroniser with asynchronous active-low clear
module jtkiwi_rstsync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/jtkiwi_shr_port.sv
// rtl/jtkiwi_shr_port.sv - sub Z80 access port onto the shared RAM's second port
module jtkiwi_shr_port
  import jtkiwi_shr_pkg::*;
#(
  parameter logic [2:0] WIN = WIN_DEF,
  parameter int         AW  = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          snd_rstn,
  output logic          sub_rst_n,
  input  logic [15:0]   sub_addr,
  input  logic [7:0]    sub_dout,
  input  logic          sub_mreq_n,
  input  logic          sub_rd_n,
  input  logic          sub_wr_n,
  input  logic          sub_rfsh_n,
  output logic          sub_ram_cs,
  output logic [7:0]    sub_din,
  output logic          dev_busy,
  output logic [AW-1:0] shr_addr,
  output logic [7:0]    shr_din,
  output logic          shr_we,
  input  logic [7:0]    shr_dout
);

  shr_state_t    state_q, state_d;
  logic [AW-1:0] shr_addr_q, shr_addr_d;
  logic [7:0]    shr_din_q, shr_din_d;
  logic          shr_we_q, shr_we_d;
  logic [7:0]    sub_din_q, sub_din_d;
  logic          sub_ram_cs_q, sub_ram_cs_d;
  logic          win_hit, sel;

  jtkiwi_rstsync u_rstsync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (snd_rstn),
    .dout  (sub_rst_n)
  );

  assign win_hit      = !sub_mreq_n && sub_rfsh_n && (sub_addr[15:13] == WIN);
  assign sel          = win_hit && (!sub_rd_n || !sub_wr_n) && sub_rst_n;
  assign sub_ram_cs_d = win_hit;

  always_comb begin
    state_d    = state_q;
    shr_addr_d = shr_addr_q;
    shr_din_d  = shr_din_q;
    shr_we_d   = 1'b0;
    sub_din_d  = sub_din_q;
    if (!sub_rst_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cen && sel) begin
            shr_addr_d = sub_addr[AW-1:0];
            // a simultaneous rd/wr strobe is treated as a write
            if (!sub_wr_n) begin
              shr_din_d = sub_dout;
              shr_we_d  = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              state_d = ST_RD;
            end
          end
        end
        ST_RD: begin
          sub_din_d = shr_dout;
          state_d   = ST_HOLD;
        end
        ST_HOLD: begin
          if (sub_mreq_n || (sub_rd_n && sub_wr_n)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shr_addr_q   <= '0;
      shr_din_q    <= 8'h00;
      shr_we_q     <= 1'b0;
      sub_din_q    <= 8'hFF;
      sub_ram_cs_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shr_addr_q   <= shr_addr_d;
      shr_din_q    <= shr_din_d;
      shr_we_q     <= shr_we_d;
      sub_din_q    <= sub_din_d;
      sub_ram_cs_q <= sub_ram_cs_d;
    end
  end

  // combinational so the CPU stalls in the very cycle it asks for a read
  assign dev_busy   = (state_q == ST_IDLE && sel && sub_wr_n) ||
                      (state_q == ST_RD && sub_rst_n);
  assign shr_addr   = shr_addr_q;
  assign shr_din    = shr_din_q;
  assign shr_we     = shr_we_q;
  assign sub_din    = sub_din_q;
  assign sub_ram_cs = sub_ram_cs_q;

endmodule

// File: tb/tb_jtkiwi_shr_port.sv
// tb/tb_jtkiwi_shr_port.sv - directed bench for jtkiwi_shr_port with a dual-port RAM model
module tb_jtkiwi_shr_port;

  logic        clk = 1'b0;
  logic        rst_n, cen, snd_rstn, sub_rst_n;
  logic [15:0] sub_addr;
  logic [7:0]  sub_dout, sub_din, shr_din, shr_dout;
  logic        sub_mreq_n, sub_rd_n, sub_wr_n, sub_rfsh_n;
  logic        sub_ram_cs, dev_busy, shr_we;
  logic [12:0] shr_addr;

  logic        main_we;
  logic [12:0] main_addr;
  logic [7:0]  main_din;
  logic [7:0]  mem [0:8191];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt;

  always #5 clk = ~clk;

  jtkiwi_shr_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .snd_rstn   (snd_rstn),
    .sub_rst_n  (sub_rst_n),
    .sub_addr   (sub_addr),
    .sub_dout   (sub_dout),
    .sub_mreq_n (sub_mreq_n),
    .sub_rd_n   (sub_rd_n),
    .sub_wr_n   (sub_wr_n),
    .sub_rfsh_n (sub_rfsh_n),
    .sub_ram_cs (sub_ram_cs),
    .sub_din    (sub_din),
    .dev_busy   (dev_busy),
    .shr_addr   (shr_addr),
    .shr_din    (shr_din),
    .shr_we     (shr_we),
    .shr_dout   (shr_dout)
  );

  always @(posedge clk) begin
    if (shr_we)  mem[shr_addr]  <= shr_din;
    if (main_we) mem[main_addr] <= main_din;
  end
  assign shr_dout = mem[shr_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic main_write(input logic [12:0] a, input logic [7:0] d);
    main_addr = a;
    main_din  = d;
    main_we   = 1'b1;
    tick();
    main_we   = 1'b0;
  endtask

  task automatic bus_idle();
    sub_mreq_n = 1'b1;
    sub_rd_n   = 1'b1;
    sub_wr_n   = 1'b1;
    sub_rfsh_n = 1'b1;
  endtask

  task automatic sub_read(input logic [15:0] a);
    sub_addr   = a;
    sub_mreq_n = 1'b0;
    sub_rd_n   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; snd_rstn = 1'b1; cen = 1'b1;
    sub_addr = 16'h0000; sub_dout = 8'h00;
    bus_idle();
    main_we = 1'b0; main_addr = '0; main_din = 8'h00;

    // reset values
    tick(); tick();
    check("rst_sub_rst_n", {15'd0, sub_rst_n}, 16'd0);
    check("rst_shr_we", {15'd0, shr_we}, 16'd0);
    check("rst_shr_addr", {3'd0, shr_addr}, 16'h0000);
    check("rst_shr_din", {8'd0, shr_din}, 16'h0000);
    check("rst_sub_din", {8'd0, sub_din}, 16'h00FF);
    check("rst_sub_ram_cs", {15'd0, sub_ram_cs}, 16'd0);
    check("rst_dev_busy", {15'd0, dev_busy}, 16'd0);

    rst_n = 1'b1;
    tick();
    check("sync_edge1", {15'd0, sub_rst_n}, 16'd0);
    tick();
    check("sync_edge2", {15'd0, sub_rst_n}, 16'd1);

    // write held for 6 cycles: one pulse only
    main_write(13'h1FFF, 8'hA5);
    main_write(13'h0010, 8'h3C);
    main_write(13'h0200, 8'h77);
    main_write(13'h0040, 8'h22);
    sub_addr = 16'hC123; sub_dout = 8'h5A;
    sub_mreq_n = 1'b0; sub_wr_n = 1'b0;
    #1;
    check("wr_busy_req", {15'd0, dev_busy}, 16'd0);
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (shr_we) we_cnt++;
      if (i == 0) begin
        check("wr_we_pulse", {15'd0, shr_we}, 16'd1);
        check("wr_addr", {3'd0, shr_addr}, 16'h0123);
        check("wr_din", {8'd0, shr_din}, 16'h005A);
        check("wr_busy", {15'd0, dev_busy}, 16'd0);
      end
    end
    bus_idle();
    tick(); tick();
    check("wr_pulse_count", we_cnt[15:0], 16'd1);
    check("wr_ram", {8'd0, mem[13'h0123]}, 16'h005A);

    // read at top of window
    sub_read(16'hDFFF);
    #1;
    check("rd_busy_req", {15'd0, dev_busy}, 16'd1);
    tick();
    check("rd_busy_e0", {15'd0, dev_busy}, 16'd1);
    check("rd_din_e0", {8'd0, sub_din}, 16'h00FF);
    check("rd_cs", {15'd0, sub_ram_cs}, 16'd1);
    tick();
    check("rd_busy_e1", {15'd0, dev_busy}, 16'd0);
    check("rd_din_e1", {8'd0, sub_din}, 16'h00A5);
    bus_idle();
    tick(); tick();

    // out-of-window read and refresh cycle are ignored
    sub_read(16'hE000);
    #1;
    check("ign_busy_e000", {15'd0, dev_busy}, 16'd0);
    tick();
    check("ign_cs_e000", {15'd0, sub_ram_cs}, 16'd0);
    check("ign_addr_e000", {3'd0, shr_addr}, 16'h1FFF);
    bus_idle();
    sub_addr = 16'hC000; sub_mreq_n = 1'b0; sub_rfsh_n = 1'b0; sub_rd_n = 1'b0;
    #1;
    check("ign_busy_rfsh", {15'd0, dev_busy}, 16'd0);
    tick();
    check("ign_cs_rfsh", {15'd0, sub_ram_cs}, 16'd0);
    check("ign_addr_rfsh", {3'd0, shr_addr}, 16'h1FFF);
    check("ign_din_rfsh", {8'd0, sub_din}, 16'h00A5);
    bus_idle();
    tick();

    // cen low holds the request in IDLE
    cen = 1'b0;
    sub_read(16'hC010);
    tick(); tick();
    check("cen_busy", {15'd0, dev_busy}, 16'd1);
    check("cen_addr", {3'd0, shr_addr}, 16'h1FFF);
    cen = 1'b1;
    tick();
    check("cen_addr_go", {3'd0, shr_addr}, 16'h0010);
    tick();
    check("cen_din", {8'd0, sub_din}, 16'h003C);
    bus_idle();
    tick(); tick();

    // abort: sub reset lands while the read sits in RD
    snd_rstn = 1'b0;
    tick();
    sub_read(16'hC200);
    #1;
    check("abt_busy_req", {15'd0, dev_busy}, 16'd1);
    tick();
    check("abt_rst_low", {15'd0, sub_rst_n}, 16'd0);
    check("abt_busy_rd", {15'd0, dev_busy}, 16'd0);
    check("abt_addr", {3'd0, shr_addr}, 16'h0200);
    tick();
    check("abt_din_kept", {8'd0, sub_din}, 16'h003C);
    check("abt_busy_after", {15'd0, dev_busy}, 16'd0);
    tick();
    check("abt_din_kept2", {8'd0, sub_din}, 16'h003C);
    bus_idle();
    snd_rstn = 1'b1;
    tick(); tick();
    check("abt_rst_back", {15'd0, sub_rst_n}, 16'd1);

    // main and sub touch the same address in the same cycle
    sub_read(16'hC040);
    main_addr = 13'h0040; main_din = 8'h11; main_we = 1'b1;
    tick();
    main_we = 1'b0;
    tick();
    n_tests++;
    assert ((sub_din === 8'h11 || sub_din === 8'h22) && !$isunknown(sub_din)) else begin
      n_fail++;
      $error("FAIL conc_din: got %h expected 22 or 11", sub_din);
    end
    bus_idle();
    tick(); tick();
    sub_read(16'hC040);
    tick(); tick();
    check("conc_reread", {8'd0, sub_din}, 16'h0011);
    bus_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
